// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the IF/ID stage.
// The fetch unit takes the master side; memory and decode together form the slave side.
interface fetch_unit_if;
   typedef logic [31:0] u32_t;

   logic imem_req;
   u32_t imem_addr;
   logic imem_gnt;
   logic imem_rvalid;
   u32_t imem_rdata;

   logic redirect_valid;
   u32_t redirect_ia;

   logic id_valid;
   logic id_ready;
   u32_t id_ir;
   u32_t id_ia_plus_4;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect_valid, redirect_ia,
      output id_valid, id_ir, id_ia_plus_4,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect_valid, redirect_ia,
      input  id_valid, id_ir, id_ia_plus_4,
      output id_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// MINA2000 instruction-fetch front end: pipelined IMEM requests, in-order fetch FIFO,
// and redirect handling that flushes buffered words and drops in-flight responses.
module fetch_unit #(
   parameter logic [31:0] INITIAL_IA = 32'h0000_0000,
   parameter int unsigned DEPTH      = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] ia_plus_4;
   } entry_t;

   logic [31:0]   ia;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;

   entry_t        fifo_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Request addresses of granted requests, consumed one per response (kept or dropped).
   logic [31:0]   addr_mem [DEPTH];
   logic [PW-1:0] a_rd_ptr;
   logic [PW-1:0] a_wr_ptr;

   logic grant;
   logic resp;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign occupancy        = {1'b0, outstanding} + {1'b0, fifo_count};
   assign bus.imem_req     = !rst && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign bus.imem_addr    = ia;

   assign grant            = bus.imem_req && bus.imem_gnt;
   assign resp             = bus.imem_rvalid;
   assign outstanding_next = outstanding + CW'(grant) - CW'(resp);
   assign push             = !rst && resp && (discard == '0) && !bus.redirect_valid;
   assign pop              = bus.id_valid && bus.id_ready;

   // Gating with rst keeps the decode side quiet during the reset cycle itself.
   assign bus.id_valid     = !rst && (fifo_count != '0);
   assign bus.id_ir        = bus.id_valid ? fifo_mem[rd_ptr].ir        : '0;
   assign bus.id_ia_plus_4 = bus.id_valid ? fifo_mem[rd_ptr].ia_plus_4 : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ia          <= INITIAL_IA;
         outstanding <= '0;
         discard     <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         a_rd_ptr    <= '0;
         a_wr_ptr    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (grant) a_wr_ptr <= ptr_inc(a_wr_ptr);
         if (resp)  a_rd_ptr <= ptr_inc(a_rd_ptr);

         if (bus.redirect_valid) begin
            ia         <= bus.redirect_ia & 32'hFFFF_FFFC;
            discard    <= outstanding_next;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
         end else begin
            if (grant) ia <= ia + 32'd4;
            if (resp && (discard != '0)) discard <= discard - CW'(1);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   // NOTE: storage arrays carry no reset; occupancy counters and the id_valid gate
   // guarantee stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push)  fifo_mem[wr_ptr]   <= '{ir: bus.imem_rdata, ia_plus_4: addr_mem[a_rd_ptr] + 32'd4};
      if (grant) addr_mem[a_wr_ptr] <= ia;
   end

   rvalid_without_request: assert property (
      @(posedge clk) disable iff (rst) !(bus.imem_rvalid && (outstanding == '0))
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an in-order memory model feeds responses,
// and a monitor compares every presented instruction against the expected queue.
module tb_fetch_unit;
   localparam logic [31:0] INITIAL_IA = 32'h0000_0000;
   localparam int          DEPTH      = 2;

   typedef struct {
      logic [31:0] mem_addr;
      logic [31:0] exp_addr;
      int          due;
      bit          stale;
   } req_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc4;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   fetch_unit_if bus ();

   fetch_unit #(.INITIAL_IA(INITIAL_IA), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          coincide_hits = 0;
   logic [31:0] model_ia = INITIAL_IA;
   req_t        pend [$];
   exp_t        exp_q [$];
   bit          prev_rst = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Monitor: compares DUT outputs against the reference state before this cycle's edge.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         check("rst_req",   32'(bus.imem_req), 32'd0);
         check("rst_valid", 32'(bus.id_valid), 32'd0);
         check("rst_ir",    bus.id_ir,         32'd0);
         check("rst_pc4",   bus.id_ia_plus_4,  32'd0);
         if (prev_rst) check("rst_addr", bus.imem_addr, INITIAL_IA);
      end else begin
         check("req", 32'(bus.imem_req),
               32'(!bus.redirect_valid && (pend.size() + exp_q.size() < DEPTH)));
         if (bus.imem_req) check("addr", bus.imem_addr, model_ia);
         check("id_valid", 32'(bus.id_valid), 32'(exp_q.size() != 0));
         if (bus.id_valid && exp_q.size() != 0) begin
            check("id_ir",  bus.id_ir,        exp_q[0].ir);
            check("id_pc4", bus.id_ia_plus_4, exp_q[0].pc4);
            if (bus.id_ready) void'(exp_q.pop_front());
         end
      end
      prev_rst = rst;
   end

   // One clock of stimulus plus the reference-model update for that clock's edge.
   task automatic step(input int gnt_p, input int rdy_p, input int lat_lo, input int lat_hi,
                       input bit redir, input logic [31:0] raddr);
      bit rv;
      @(negedge clk);
      rst                = 1'b0;
      bus.imem_gnt       = ($urandom_range(0, 99) < gnt_p);
      bus.id_ready       = ($urandom_range(0, 99) < rdy_p);
      bus.redirect_valid = redir;
      bus.redirect_ia    = raddr;
      rv                 = (pend.size() != 0) && (pend[0].due <= cyc);
      bus.imem_rvalid    = rv;
      bus.imem_rdata     = rv ? mem_word(pend[0].mem_addr) : $urandom;
      #2;
      if (rv) begin
         req_t r;
         r = pend.pop_front();
         if (redir) coincide_hits++;
         if (!r.stale && !redir) exp_q.push_back('{ir: mem_word(r.exp_addr), pc4: r.exp_addr + 32'd4});
      end
      if (bus.imem_req && bus.imem_gnt) begin
         pend.push_back('{mem_addr: bus.imem_addr, exp_addr: model_ia,
                          due: cyc + $urandom_range(lat_lo, lat_hi), stale: 1'b0});
         model_ia = model_ia + 32'd4;
      end
      if (redir) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_q.delete();
         model_ia = raddr & 32'hFFFF_FFFC;
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst                = 1'b1;
         bus.imem_gnt       = 1'b0;
         bus.imem_rvalid    = 1'b0;
         bus.imem_rdata     = '0;
         bus.redirect_valid = 1'b0;
         bus.redirect_ia    = '0;
         bus.id_ready       = 1'b0;
         #2;
         pend.delete();
         exp_q.delete();
         model_ia = INITIAL_IA;
         cyc++;
      end
   endtask

   initial begin
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_ia    = '0;
      bus.id_ready       = 1'b0;
      do_reset(3);

      // Free flow at 1-cycle latency.
      for (int i = 0; i < 30; i++) step(100, 100, 1, 1, 1'b0, '0);

      // Backpressure: decode stalls for 10 cycles, then drains.
      for (int i = 0; i < 10; i++) step(100, 0, 1, 1, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(100, 100, 1, 1, 1'b0, '0);

      // Redirect with two requests in flight at 3-cycle latency.
      for (int i = 0; i < 8; i++) step(0, 100, 1, 1, 1'b0, '0);
      step(100, 100, 3, 3, 1'b0, '0);
      step(100, 100, 3, 3, 1'b0, '0);
      step(100, 100, 3, 3, 1'b1, 32'h0000_0103);
      for (int i = 0; i < 12; i++) step(100, 100, 3, 3, 1'b0, '0);

      // Redirect landing on a response cycle with imem_gnt high.
      for (int i = 0; i < 5; i++) step(100, 100, 1, 1, 1'b0, '0);
      while (!(pend.size() != 0 && pend[0].due <= cyc) && cyc < 2000)
         step(100, 100, 1, 1, 1'b0, '0);
      step(100, 100, 1, 1, 1'b1, 32'h0000_0200);
      for (int i = 0; i < 12; i++) step(100, 100, 1, 1, 1'b0, '0);

      // Address wrap-around.
      step(100, 100, 1, 1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 12; i++) step(100, 100, 1, 1, 1'b0, '0);

      // Reset mid-stream with the FIFO full.
      for (int i = 0; i < 8; i++) step(100, 0, 1, 1, 1'b0, '0);
      do_reset(1);
      for (int i = 0; i < 12; i++) step(100, 100, 1, 1, 1'b0, '0);

      // Random traffic with sporadic redirects.
      for (int i = 0; i < 3000; i++)
         step(60, 70, 1, 4, ($urandom_range(0, 99) < 3), $urandom);

      // Drain: stop granting so everything in flight retires.
      for (int i = 0; i < 30; i++) step(0, 100, 1, 4, 1'b0, '0);
      @(negedge clk);
      #3;
      check("final_idle", 32'(bus.id_valid), 32'd0);
      check("coincide_seen", 32'(coincide_hits > 0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
